mole_spawner: RTL

Game sequencer that drives the load side of the mole board register. On `start` it runs a fixed number of rounds. Each round it pops a pseudo-random mole pattern onto the board, holds it for a programmable up-time, then clears the board and counts every mole still standing as a miss. It sits upstream of the board register: it drives that block's load/loadval inputs and reads back its board_state output.

---
 rtl/whack_pkg.sv | 24 ++
 rtl/mole_lfsr.sv | 28 ++
 rtl/mole_spawner.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/whack_pkg.sv
// Shared types and helpers for the whack-a-mole sequencer.
// Holds the FSM state encoding, board width, LFSR taps and the popcount helper.
package whack_pkg;

  localparam int N_MOLES = 5;

  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_UP,
    S_CLEAR,
    S_GAP,
    S_DONE
  } state_t;

  function automatic logic [2:0] popcount5(input logic [4:0] v);
    popcount5 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]}
              + {2'b00, v[3]} + {2'b00, v[4]};
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Fibonacci LFSR, advances every cycle, reloads SEED on reset.
// Output is the register itself (no combinational path); no backpressure.
module mole_lfsr
  import whack_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [15:0] o_lfsr
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb = ^(r_lfsr & LFSR_TAPS);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/mole_spawner.sv
// Game sequencer driving the mole board register's load port; outputs are registered,
// so start at edge k shows SPAWN/load in cycle k+1. No backpressure: board_state is sampled every cycle.
module mole_spawner
  import whack_pkg::*;
#(
  parameter int          TICK_DIV   = 100000,
  parameter int          MOLE_TICKS = 8,
  parameter int          GAP_TICKS  = 2,
  parameter int          ROUNDS     = 30,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [N_MOLES-1:0] i_board_state,
  output logic               o_load,
  output logic [N_MOLES-1:0] o_loadval,
  output logic [7:0]         o_round_count,
  output logic [7:0]         o_miss_count,
  output logic               o_busy,
  output logic               o_game_over
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAXT = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS;
  localparam int TW   = $clog2(MAXT + 1);

  state_t              r_state;
  state_t              w_next;
  logic [PW-1:0]       r_presc;
  logic [TW-1:0]       r_tick_cnt;
  logic [7:0]          r_round;
  logic [7:0]          r_miss;
  logic                r_load;
  logic [N_MOLES-1:0]  r_loadval;
  logic                r_busy;
  logic                r_game_over;

  logic [15:0]         w_lfsr;
  logic                w_unused_lfsr;
  logic [N_MOLES-1:0]  w_slice;
  logic [N_MOLES-1:0]  w_pattern;
  logic                w_tick;
  logic                w_up_done;
  logic                w_gap_done;
  logic                w_enter;
  logic                w_begin;
  logic [8:0]          w_miss_sum;
  logic [7:0]          w_miss_sat;

  mole_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_lfsr (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr[15:N_MOLES];
  assign w_slice       = w_lfsr[N_MOLES-1:0];
  assign w_pattern     = (w_slice == '0) ? N_MOLES'(1) : w_slice;

  // Exit fires on the last cycle of the final tick so each phase lasts exactly TICKS*TICK_DIV cycles.
  assign w_tick     = (r_presc == PW'(TICK_DIV - 1));
  assign w_up_done  = w_tick && (r_tick_cnt == TW'(MOLE_TICKS - 1));
  assign w_gap_done = w_tick && (r_tick_cnt == TW'(GAP_TICKS - 1));

  assign w_begin = ((r_state == S_IDLE) || (r_state == S_DONE)) && i_start;
  assign w_enter = ((w_next == S_UP)  && (r_state != S_UP)) ||
                   ((w_next == S_GAP) && (r_state != S_GAP));

  assign w_miss_sum = {1'b0, r_miss} + {6'd0, popcount5(i_board_state)};
  assign w_miss_sat = w_miss_sum[8] ? 8'hFF : w_miss_sum[7:0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_SPAWN;
      S_SPAWN: w_next = S_UP;
      S_UP:    if ((i_board_state == '0) || w_up_done) w_next = S_CLEAR;
      S_CLEAR: w_next = S_GAP;
      S_GAP: begin
        if (w_gap_done) begin
          w_next = (r_round == 8'(ROUNDS)) ? S_DONE : S_SPAWN;
        end
      end
      S_DONE:  if (i_start) w_next = S_SPAWN;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc    <= '0;
      r_tick_cnt <= '0;
    end else if (w_enter) begin
      r_presc    <= '0;
      r_tick_cnt <= '0;
    end else if ((r_state == S_UP) || (r_state == S_GAP)) begin
      if (w_tick) begin
        r_presc    <= '0;
        r_tick_cnt <= r_tick_cnt + TW'(1);
      end else begin
        r_presc    <= r_presc + PW'(1);
      end
    end
  end

  // Round count already reads 1 during the first SPAWN cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_round <= 8'd0;
      r_miss  <= 8'd0;
    end else if (w_begin) begin
      r_round <= 8'd1;
      r_miss  <= 8'd0;
    end else begin
      if ((r_state == S_GAP) && (w_next == S_SPAWN)) begin
        r_round <= r_round + 8'd1;
      end
      if (r_state == S_CLEAR) begin
        r_miss <= w_miss_sat;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_load      <= 1'b0;
      r_loadval   <= '0;
      r_busy      <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_load      <= (w_next == S_SPAWN) || (w_next == S_CLEAR);
      r_loadval   <= (w_next == S_SPAWN) ? w_pattern : '0;
      r_busy      <= (w_next == S_SPAWN) || (w_next == S_UP) ||
                     (w_next == S_CLEAR) || (w_next == S_GAP);
      r_game_over <= (w_next == S_DONE);
    end
  end

  assign o_load        = r_load;
  assign o_loadval     = r_loadval;
  assign o_round_count = r_round;
  assign o_miss_count  = r_miss;
  assign o_busy        = r_busy;
  assign o_game_over   = r_game_over;

endmodule
